// File: rtl/ddr_axi_arb2_pkg.sv
// Shared types and constants for the two-master DDR AXI arbiter.
package ddr_arb_pkg;

  // Arbiter sequencing: one burst (write or read) in flight at a time.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R
  } arb_state_e;

  // AXI response codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // AXI burst type
  localparam logic [1:0] INCR   = 2'b01;

  // Round-robin pick between two requesters: prefer the master that was not
  // served last; fall back to the other one when it is the only requester.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    logic win;
    if (last) win = req[0] ? 1'b0 : 1'b1;
    else      win = req[1] ? 1'b1 : 1'b0;
    return win;
  endfunction

endpackage

// File: rtl/ddr_axi_arb2.sv
// Two-master to one-slave AXI4 arbiter in front of the LiteDRAM AXI port.
// Exactly one burst is in flight; grants are round-robin and held off until
// DDR init has completed. Responses are routed by the grant, not by ID.
import ddr_arb_pkg::*;

module ddr_axi_arb2 #(
  parameter int ID_WIDTH   = 6,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_init_done,

  // master 0
  input  logic [ID_WIDTH-1:0]     s0_aw_id,
  input  logic [ADDR_WIDTH-1:0]   s0_aw_addr,
  input  logic [7:0]              s0_aw_len,
  input  logic [2:0]              s0_aw_size,
  input  logic [1:0]              s0_aw_burst,
  input  logic                    s0_aw_valid,
  output logic                    s0_aw_ready,
  input  logic [DATA_WIDTH-1:0]   s0_w_data,
  input  logic [DATA_WIDTH/8-1:0] s0_w_strb,
  input  logic                    s0_w_last,
  input  logic                    s0_w_valid,
  output logic                    s0_w_ready,
  output logic [ID_WIDTH-1:0]     s0_b_id,
  output logic [1:0]              s0_b_resp,
  output logic                    s0_b_valid,
  input  logic                    s0_b_ready,
  input  logic [ID_WIDTH-1:0]     s0_ar_id,
  input  logic [ADDR_WIDTH-1:0]   s0_ar_addr,
  input  logic [7:0]              s0_ar_len,
  input  logic [2:0]              s0_ar_size,
  input  logic [1:0]              s0_ar_burst,
  input  logic                    s0_ar_valid,
  output logic                    s0_ar_ready,
  output logic [ID_WIDTH-1:0]     s0_r_id,
  output logic [DATA_WIDTH-1:0]   s0_r_data,
  output logic [1:0]              s0_r_resp,
  output logic                    s0_r_last,
  output logic                    s0_r_valid,
  input  logic                    s0_r_ready,

  // master 1
  input  logic [ID_WIDTH-1:0]     s1_aw_id,
  input  logic [ADDR_WIDTH-1:0]   s1_aw_addr,
  input  logic [7:0]              s1_aw_len,
  input  logic [2:0]              s1_aw_size,
  input  logic [1:0]              s1_aw_burst,
  input  logic                    s1_aw_valid,
  output logic                    s1_aw_ready,
  input  logic [DATA_WIDTH-1:0]   s1_w_data,
  input  logic [DATA_WIDTH/8-1:0] s1_w_strb,
  input  logic                    s1_w_last,
  input  logic                    s1_w_valid,
  output logic                    s1_w_ready,
  output logic [ID_WIDTH-1:0]     s1_b_id,
  output logic [1:0]              s1_b_resp,
  output logic                    s1_b_valid,
  input  logic                    s1_b_ready,
  input  logic [ID_WIDTH-1:0]     s1_ar_id,
  input  logic [ADDR_WIDTH-1:0]   s1_ar_addr,
  input  logic [7:0]              s1_ar_len,
  input  logic [2:0]              s1_ar_size,
  input  logic [1:0]              s1_ar_burst,
  input  logic                    s1_ar_valid,
  output logic                    s1_ar_ready,
  output logic [ID_WIDTH-1:0]     s1_r_id,
  output logic [DATA_WIDTH-1:0]   s1_r_data,
  output logic [1:0]              s1_r_resp,
  output logic                    s1_r_last,
  output logic                    s1_r_valid,
  input  logic                    s1_r_ready,

  // slave side toward LiteDRAM
  output logic [ID_WIDTH-1:0]     m_aw_id,
  output logic [ADDR_WIDTH-1:0]   m_aw_addr,
  output logic [7:0]              m_aw_len,
  output logic [2:0]              m_aw_size,
  output logic [1:0]              m_aw_burst,
  output logic                    m_aw_valid,
  input  logic                    m_aw_ready,
  output logic [DATA_WIDTH-1:0]   m_w_data,
  output logic [DATA_WIDTH/8-1:0] m_w_strb,
  output logic                    m_w_last,
  output logic                    m_w_valid,
  input  logic                    m_w_ready,
  input  logic [ID_WIDTH-1:0]     m_b_id,
  input  logic [1:0]              m_b_resp,
  input  logic                    m_b_valid,
  output logic                    m_b_ready,
  output logic [ID_WIDTH-1:0]     m_ar_id,
  output logic [ADDR_WIDTH-1:0]   m_ar_addr,
  output logic [7:0]              m_ar_len,
  output logic [2:0]              m_ar_size,
  output logic [1:0]              m_ar_burst,
  output logic                    m_ar_valid,
  input  logic                    m_ar_ready,
  input  logic [ID_WIDTH-1:0]     m_r_id,
  input  logic [DATA_WIDTH-1:0]   m_r_data,
  input  logic [1:0]              m_r_resp,
  input  logic                    m_r_last,
  input  logic                    m_r_valid,
  output logic                    m_r_ready,

  output logic                    o_wlast_err
);

  arb_state_e state, state_n;
  logic       g, g_n;
  logic       last, last_n;
  logic       win;
  logic [7:0] cnt;
  logic [7:0] len_q;

  logic st_aw, st_w, st_b, st_ar, st_r;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic grant;

  // granted master's request channels
  logic [ID_WIDTH-1:0]     sg_aw_id;
  logic [ADDR_WIDTH-1:0]   sg_aw_addr;
  logic [7:0]              sg_aw_len;
  logic [2:0]              sg_aw_size;
  logic [1:0]              sg_aw_burst;
  logic                    sg_aw_valid;
  logic [DATA_WIDTH-1:0]   sg_w_data;
  logic [DATA_WIDTH/8-1:0] sg_w_strb;
  logic                    sg_w_last;
  logic                    sg_w_valid;
  logic                    sg_b_ready;
  logic [ID_WIDTH-1:0]     sg_ar_id;
  logic [ADDR_WIDTH-1:0]   sg_ar_addr;
  logic [7:0]              sg_ar_len;
  logic [2:0]              sg_ar_size;
  logic [1:0]              sg_ar_burst;
  logic                    sg_ar_valid;
  logic                    sg_r_ready;

  assign st_aw = (state == ST_AW);
  assign st_w  = (state == ST_W);
  assign st_b  = (state == ST_B);
  assign st_ar = (state == ST_AR);
  assign st_r  = (state == ST_R);

  assign sg_aw_id    = g ? s1_aw_id    : s0_aw_id;
  assign sg_aw_addr  = g ? s1_aw_addr  : s0_aw_addr;
  assign sg_aw_len   = g ? s1_aw_len   : s0_aw_len;
  assign sg_aw_size  = g ? s1_aw_size  : s0_aw_size;
  assign sg_aw_burst = g ? s1_aw_burst : s0_aw_burst;
  assign sg_aw_valid = g ? s1_aw_valid : s0_aw_valid;
  assign sg_w_data   = g ? s1_w_data   : s0_w_data;
  assign sg_w_strb   = g ? s1_w_strb   : s0_w_strb;
  assign sg_w_last   = g ? s1_w_last   : s0_w_last;
  assign sg_w_valid  = g ? s1_w_valid  : s0_w_valid;
  assign sg_b_ready  = g ? s1_b_ready  : s0_b_ready;
  assign sg_ar_id    = g ? s1_ar_id    : s0_ar_id;
  assign sg_ar_addr  = g ? s1_ar_addr  : s0_ar_addr;
  assign sg_ar_len   = g ? s1_ar_len   : s0_ar_len;
  assign sg_ar_size  = g ? s1_ar_size  : s0_ar_size;
  assign sg_ar_burst = g ? s1_ar_burst : s0_ar_burst;
  assign sg_ar_valid = g ? s1_ar_valid : s0_ar_valid;
  assign sg_r_ready  = g ? s1_r_ready  : s0_r_ready;

  // Slave-side request channels: payload always follows g, valids only in
  // the owning state so IDLE (and reset) drives nothing.
  assign m_aw_id    = sg_aw_id;
  assign m_aw_addr  = sg_aw_addr;
  assign m_aw_len   = sg_aw_len;
  assign m_aw_size  = sg_aw_size;
  assign m_aw_burst = sg_aw_burst;
  assign m_aw_valid = st_aw & sg_aw_valid;
  assign m_w_data   = sg_w_data;
  assign m_w_strb   = sg_w_strb;
  assign m_w_last   = sg_w_last;
  assign m_w_valid  = st_w & sg_w_valid;
  assign m_b_ready  = st_b & sg_b_ready;
  assign m_ar_id    = sg_ar_id;
  assign m_ar_addr  = sg_ar_addr;
  assign m_ar_len   = sg_ar_len;
  assign m_ar_size  = sg_ar_size;
  assign m_ar_burst = sg_ar_burst;
  assign m_ar_valid = st_ar & sg_ar_valid;
  assign m_r_ready  = st_r & sg_r_ready;

  // Master-side readies and response valids, only toward the granted master.
  assign s0_aw_ready = st_aw & ~g & m_aw_ready;
  assign s1_aw_ready = st_aw &  g & m_aw_ready;
  assign s0_w_ready  = st_w  & ~g & m_w_ready;
  assign s1_w_ready  = st_w  &  g & m_w_ready;
  assign s0_ar_ready = st_ar & ~g & m_ar_ready;
  assign s1_ar_ready = st_ar &  g & m_ar_ready;

  assign s0_b_id    = m_b_id;
  assign s0_b_resp  = m_b_resp;
  assign s0_b_valid = st_b & ~g & m_b_valid;
  assign s1_b_id    = m_b_id;
  assign s1_b_resp  = m_b_resp;
  assign s1_b_valid = st_b &  g & m_b_valid;

  assign s0_r_id    = m_r_id;
  assign s0_r_data  = m_r_data;
  assign s0_r_resp  = m_r_resp;
  assign s0_r_last  = m_r_last;
  assign s0_r_valid = st_r & ~g & m_r_valid;
  assign s1_r_id    = m_r_id;
  assign s1_r_data  = m_r_data;
  assign s1_r_resp  = m_r_resp;
  assign s1_r_last  = m_r_last;
  assign s1_r_valid = st_r &  g & m_r_valid;

  assign aw_hs = m_aw_valid & m_aw_ready;
  assign w_hs  = m_w_valid  & m_w_ready;
  assign b_hs  = m_b_valid  & m_b_ready;
  assign ar_hs = m_ar_valid & m_ar_ready;
  assign r_hs  = m_r_valid  & m_r_ready;

  assign grant = (state == ST_IDLE) & (state_n != ST_IDLE);

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      g     <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      g     <= g_n;
      last  <= last_n;
    end
  end

  // Next-state: registered grant decision in IDLE, then walk the burst.
  always_comb begin
    state_n = state;
    g_n     = g;
    last_n  = last;
    win     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_init_done && (s0_aw_valid | s0_ar_valid | s1_aw_valid | s1_ar_valid)) begin
          win     = rr_pick({s1_aw_valid | s1_ar_valid, s0_aw_valid | s0_ar_valid}, last);
          g_n     = win;
          state_n = (win ? s1_aw_valid : s0_aw_valid) ? ST_AW : ST_AR;
        end
      end
      ST_AW: if (aw_hs) state_n = ST_W;
      ST_W:  if (w_hs && m_w_last) state_n = ST_B;
      ST_B: begin
        if (b_hs) begin
          state_n = ST_IDLE;
          last_n  = g;
        end
      end
      ST_AR: if (ar_hs) state_n = ST_R;
      ST_R: begin
        if (r_hs && m_r_last) begin
          state_n = ST_IDLE;
          last_n  = g;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Beat counter and sticky w_last/length mismatch flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt         <= 8'd0;
      o_wlast_err <= 1'b0;
    end else begin
      if (grant) cnt <= 8'd0;
      else if (w_hs) cnt <= cnt + 8'd1;
      if (w_hs && (m_w_last != (cnt == len_q))) o_wlast_err <= 1'b1;
    end
  end

  // Burst length captured on the address handshake (data path, no reset).
  always_ff @(posedge clk) begin
    if (aw_hs) len_q <= m_aw_len;
    else if (ar_hs) len_q <= m_ar_len;
  end

endmodule

// File: tb/tb_ddr_axi_arb2.sv
// Self-checking bench for ddr_axi_arb2: master and slave models around the
// arbiter, with a scoreboard of expected grants, W beats, B and R responses.
import ddr_arb_pkg::*;

module tb_ddr_axi_arb2;

  localparam int IW = 6;
  localparam int AW = 32;
  localparam int DW = 64;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    int            nb;
  } wr_t;

  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [7:0]    len;
  } rd_t;

  typedef struct {
    int            m;
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic [DW-1:0] data;
    logic          last;
  } rsp_t;

  logic clk = 1'b0;
  logic rstn;
  logic init_done;

  logic [IW-1:0]  aw_id    [2];
  logic [AW-1:0]  aw_addr  [2];
  logic [7:0]     aw_len   [2];
  logic [2:0]     aw_size  [2];
  logic [1:0]     aw_burst [2];
  logic           aw_valid [2];
  logic           aw_ready [2];
  logic [DW-1:0]  w_data   [2];
  logic [DW/8-1:0] w_strb  [2];
  logic           w_last   [2];
  logic           w_valid  [2];
  logic           w_ready  [2];
  logic [IW-1:0]  b_id     [2];
  logic [1:0]     b_resp   [2];
  logic           b_valid  [2];
  logic           b_ready  [2];
  logic [IW-1:0]  ar_id    [2];
  logic [AW-1:0]  ar_addr  [2];
  logic [7:0]     ar_len   [2];
  logic [2:0]     ar_size  [2];
  logic [1:0]     ar_burst [2];
  logic           ar_valid [2];
  logic           ar_ready [2];
  logic [IW-1:0]  r_id     [2];
  logic [DW-1:0]  r_data   [2];
  logic [1:0]     r_resp   [2];
  logic           r_last   [2];
  logic           r_valid  [2];
  logic           r_ready  [2];

  logic [IW-1:0]   m_aw_id;
  logic [AW-1:0]   m_aw_addr;
  logic [7:0]      m_aw_len;
  logic [2:0]      m_aw_size;
  logic [1:0]      m_aw_burst;
  logic            m_aw_valid;
  logic            m_aw_ready;
  logic [DW-1:0]   m_w_data;
  logic [DW/8-1:0] m_w_strb;
  logic            m_w_last;
  logic            m_w_valid;
  logic            m_w_ready;
  logic [IW-1:0]   m_b_id;
  logic [1:0]      m_b_resp;
  logic            m_b_valid;
  logic            m_b_ready;
  logic [IW-1:0]   m_ar_id;
  logic [AW-1:0]   m_ar_addr;
  logic [7:0]      m_ar_len;
  logic [2:0]      m_ar_size;
  logic [1:0]      m_ar_burst;
  logic            m_ar_valid;
  logic            m_ar_ready;
  logic [IW-1:0]   m_r_id;
  logic [DW-1:0]   m_r_data;
  logic [1:0]      m_r_resp;
  logic            m_r_last;
  logic            m_r_valid;
  logic            m_r_ready;
  logic            wlast_err;

  ddr_axi_arb2 #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rstn(rstn), .i_init_done(init_done),
    .s0_aw_id(aw_id[0]), .s0_aw_addr(aw_addr[0]), .s0_aw_len(aw_len[0]),
    .s0_aw_size(aw_size[0]), .s0_aw_burst(aw_burst[0]), .s0_aw_valid(aw_valid[0]),
    .s0_aw_ready(aw_ready[0]),
    .s0_w_data(w_data[0]), .s0_w_strb(w_strb[0]), .s0_w_last(w_last[0]),
    .s0_w_valid(w_valid[0]), .s0_w_ready(w_ready[0]),
    .s0_b_id(b_id[0]), .s0_b_resp(b_resp[0]), .s0_b_valid(b_valid[0]), .s0_b_ready(b_ready[0]),
    .s0_ar_id(ar_id[0]), .s0_ar_addr(ar_addr[0]), .s0_ar_len(ar_len[0]),
    .s0_ar_size(ar_size[0]), .s0_ar_burst(ar_burst[0]), .s0_ar_valid(ar_valid[0]),
    .s0_ar_ready(ar_ready[0]),
    .s0_r_id(r_id[0]), .s0_r_data(r_data[0]), .s0_r_resp(r_resp[0]), .s0_r_last(r_last[0]),
    .s0_r_valid(r_valid[0]), .s0_r_ready(r_ready[0]),
    .s1_aw_id(aw_id[1]), .s1_aw_addr(aw_addr[1]), .s1_aw_len(aw_len[1]),
    .s1_aw_size(aw_size[1]), .s1_aw_burst(aw_burst[1]), .s1_aw_valid(aw_valid[1]),
    .s1_aw_ready(aw_ready[1]),
    .s1_w_data(w_data[1]), .s1_w_strb(w_strb[1]), .s1_w_last(w_last[1]),
    .s1_w_valid(w_valid[1]), .s1_w_ready(w_ready[1]),
    .s1_b_id(b_id[1]), .s1_b_resp(b_resp[1]), .s1_b_valid(b_valid[1]), .s1_b_ready(b_ready[1]),
    .s1_ar_id(ar_id[1]), .s1_ar_addr(ar_addr[1]), .s1_ar_len(ar_len[1]),
    .s1_ar_size(ar_size[1]), .s1_ar_burst(ar_burst[1]), .s1_ar_valid(ar_valid[1]),
    .s1_ar_ready(ar_ready[1]),
    .s1_r_id(r_id[1]), .s1_r_data(r_data[1]), .s1_r_resp(r_resp[1]), .s1_r_last(r_last[1]),
    .s1_r_valid(r_valid[1]), .s1_r_ready(r_ready[1]),
    .m_aw_id(m_aw_id), .m_aw_addr(m_aw_addr), .m_aw_len(m_aw_len), .m_aw_size(m_aw_size),
    .m_aw_burst(m_aw_burst), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_last(m_w_last),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_b_id(m_b_id), .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .m_ar_id(m_ar_id), .m_ar_addr(m_ar_addr), .m_ar_len(m_ar_len), .m_ar_size(m_ar_size),
    .m_ar_burst(m_ar_burst), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_id(m_r_id), .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_last(m_r_last),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready),
    .o_wlast_err(wlast_err)
  );

  initial forever #5 clk = ~clk;

  // master models
  wr_t wq [2][$];
  rd_t rq [2][$];
  bit  aw_sent [2];
  bit  ar_sent [2];
  int  wbeat   [2];
  int  r_seen  [2];

  // slave model
  logic [IW-1:0] bq [$];
  rd_t           rs [$];
  int            rbeat;
  logic [IW-1:0] s_wid;
  bit            stall;

  // scoreboard
  logic [IW-1:0] exp_gnt [$];
  logic [DW-1:0] exp_w   [$];
  rsp_t          exp_b   [$];
  rsp_t          exp_r   [$];

  int n_tests = 0;
  int n_fail  = 0;
  int b_seen  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] wd(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                       input int beat);
    logic [15:0] b16;
    b16 = beat[15:0];
    return {addr, 10'd0, id, b16};
  endfunction

  function automatic logic [1:0] rresp_of(input logic [AW-1:0] addr);
    return addr[12] ? SLVERR : OKAY;
  endfunction

  function automatic bit busy();
    return (wq[0].size() != 0) || (wq[1].size() != 0) || (rq[0].size() != 0) ||
           (rq[1].size() != 0) || (exp_gnt.size() != 0) || (exp_w.size() != 0) ||
           (exp_b.size() != 0) || (exp_r.size() != 0);
  endfunction

  task automatic push_write(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input logic [7:0] len, input int nb);
    wr_t  t;
    rsp_t e;
    t.id = id; t.addr = addr; t.len = len; t.nb = nb;
    wq[m].push_back(t);
    exp_gnt.push_back(id);
    for (int b = 0; b < nb; b++) exp_w.push_back(wd(id, addr, b));
    e.m = m; e.id = id; e.resp = OKAY; e.data = '0; e.last = 1'b1;
    exp_b.push_back(e);
  endtask

  task automatic push_read(input int m, input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len);
    rd_t  t;
    rsp_t e;
    t.id = id; t.addr = addr; t.len = len;
    rq[m].push_back(t);
    exp_gnt.push_back(id);
    for (int b = 0; b <= int'(len); b++) begin
      e.m = m; e.id = id; e.resp = rresp_of(addr); e.data = ~wd(id, addr, b);
      e.last = (b == int'(len));
      exp_r.push_back(e);
    end
  endtask

  task automatic clear_models();
    for (int m = 0; m < 2; m++) begin
      wq[m].delete(); rq[m].delete();
      aw_sent[m] = 0; ar_sent[m] = 0; wbeat[m] = 0; r_seen[m] = 0;
    end
    bq.delete(); rs.delete(); rbeat = 0; s_wid = '0;
    exp_gnt.delete(); exp_w.delete(); exp_b.delete(); exp_r.delete();
  endtask

  // Drive all DUT inputs from the model state (called just after negedge).
  task automatic apply();
    wr_t w;
    rd_t r;
    for (int m = 0; m < 2; m++) begin
      aw_valid[m] = 1'b0; w_valid[m] = 1'b0; w_last[m] = 1'b0; ar_valid[m] = 1'b0;
      aw_size[m] = 3'd3; aw_burst[m] = INCR; ar_size[m] = 3'd3; ar_burst[m] = INCR;
      w_strb[m] = '1; b_ready[m] = 1'b1; r_ready[m] = 1'b1;
      if (wq[m].size() != 0) begin
        w = wq[m][0];
        aw_valid[m] = !aw_sent[m];
        aw_id[m] = w.id; aw_addr[m] = w.addr; aw_len[m] = w.len;
        w_valid[m] = (wbeat[m] < w.nb);
        w_data[m] = wd(w.id, w.addr, wbeat[m]);
        w_last[m] = (wbeat[m] == w.nb - 1);
      end
      if (rq[m].size() != 0) begin
        r = rq[m][0];
        ar_valid[m] = !ar_sent[m];
        ar_id[m] = r.id; ar_addr[m] = r.addr; ar_len[m] = r.len;
      end
    end
    m_aw_ready = 1'b1;
    m_ar_ready = 1'b1;
    m_w_ready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
    m_b_valid  = (bq.size() != 0);
    m_b_id     = (bq.size() != 0) ? bq[0] : '0;
    m_b_resp   = OKAY;
    m_r_valid  = (rs.size() != 0);
    if (rs.size() != 0) begin
      r = rs[0];
      m_r_id = r.id; m_r_data = ~wd(r.id, r.addr, rbeat);
      m_r_last = (rbeat == int'(r.len)); m_r_resp = rresp_of(r.addr);
    end else begin
      m_r_id = '0; m_r_data = '0; m_r_last = 1'b0; m_r_resp = OKAY;
    end
  endtask

  // Evaluate the handshakes that the coming posedge will take; update models.
  task automatic observe();
    rsp_t e;
    rd_t  r;
    if (m_aw_valid && m_aw_ready) begin
      s_wid = m_aw_id;
      chk("aw_burst", 64'(m_aw_burst), 64'(INCR));
      if (exp_gnt.size() == 0) chk("aw_unexp", 64'(1), 64'(0));
      else chk("gnt_aw_id", 64'(m_aw_id), 64'(exp_gnt.pop_front()));
    end
    if (m_w_valid && m_w_ready) begin
      if (exp_w.size() == 0) chk("w_unexp", 64'(1), 64'(0));
      else chk("w_data", m_w_data, exp_w.pop_front());
      if (m_w_last) bq.push_back(s_wid);
    end
    if (m_b_valid && m_b_ready) void'(bq.pop_front());
    if (m_ar_valid && m_ar_ready) begin
      if (exp_gnt.size() == 0) chk("ar_unexp", 64'(1), 64'(0));
      else chk("gnt_ar_id", 64'(m_ar_id), 64'(exp_gnt.pop_front()));
      r.id = m_ar_id; r.addr = m_ar_addr; r.len = m_ar_len;
      rs.push_back(r);
    end
    if (m_r_valid && m_r_ready) begin
      if (m_r_last) begin
        void'(rs.pop_front());
        rbeat = 0;
      end else rbeat++;
    end
    for (int m = 0; m < 2; m++) begin
      if (aw_valid[m] && aw_ready[m]) aw_sent[m] = 1;
      if (w_valid[m] && w_ready[m]) wbeat[m]++;
      if (ar_valid[m] && ar_ready[m]) ar_sent[m] = 1;
      if (b_valid[m] && b_ready[m]) begin
        b_seen++;
        if (exp_b.size() == 0) chk("b_unexp", 64'(1), 64'(0));
        else begin
          e = exp_b.pop_front();
          chk("b_master", 64'(m), 64'(e.m));
          chk("b_id", 64'(b_id[m]), 64'(e.id));
          chk("b_resp", 64'(b_resp[m]), 64'(e.resp));
        end
        if (wq[m].size() != 0) void'(wq[m].pop_front());
        aw_sent[m] = 0; wbeat[m] = 0;
      end
      if (r_valid[m] && r_ready[m]) begin
        r_seen[m]++;
        if (exp_r.size() == 0) chk("r_unexp", 64'(1), 64'(0));
        else begin
          e = exp_r.pop_front();
          chk("r_master", 64'(m), 64'(e.m));
          chk("r_id", 64'(r_id[m]), 64'(e.id));
          chk("r_data", r_data[m], e.data);
          chk("r_resp", 64'(r_resp[m]), 64'(e.resp));
          chk("r_last", 64'(r_last[m]), 64'(e.last));
        end
        if (r_last[m]) begin
          if (rq[m].size() != 0) void'(rq[m].pop_front());
          ar_sent[m] = 0;
        end
      end
    end
  endtask

  task automatic cyc();
    #1;
    observe();
    @(posedge clk);
    @(negedge clk);
    apply();
  endtask

  task automatic drain(input int budget, input string tag);
    int k;
    k = 0;
    while (busy() && k < budget) begin
      cyc();
      k++;
    end
    chk(tag, 64'(busy()), 64'(0));
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_models();
    apply();
    repeat (3) cyc();
    rstn = 1'b1;
  endtask

  function automatic logic [14:0] ctrl_vec();
    return {m_aw_valid, m_w_valid, m_ar_valid, m_b_ready, m_r_ready,
            aw_ready[0], aw_ready[1], w_ready[0], w_ready[1], ar_ready[0], ar_ready[1],
            b_valid[0], b_valid[1], r_valid[0], r_valid[1]};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rstn = 1'b0;
    init_done = 1'b0;
    stall = 0;
    @(negedge clk);

    // reset state
    do_reset();
    #1;
    chk("rst_ctrl_quiet", 64'(ctrl_vec()), 64'(0));
    chk("rst_wlast_err", 64'(wlast_err), 64'(0));

    // grants withheld until init_done, then one-cycle arbitration latency
    push_read(0, 6'h01, 32'h0000_0100, 8'd0);
    apply();
    repeat (10) begin
      cyc();
      #1;
      chk("gate_m_ar_valid", 64'(m_ar_valid), 64'(0));
      chk("gate_s0_ar_ready", 64'(ar_ready[0]), 64'(0));
    end
    init_done = 1'b1;
    #1;
    chk("lat_same_cycle", 64'(m_ar_valid), 64'(0));
    cyc();
    #1;
    chk("lat_next_cycle", 64'(m_ar_valid), 64'(1));
    drain(50, "t1_timeout");

    // s0 write (len 3) against s1 read (len 0): write first, routed by grant
    do_reset();
    push_write(0, 6'h02, 32'h0000_2000, 8'd3, 4);
    push_read(1, 6'h21, 32'h0000_1000, 8'd0);
    apply();
    drain(100, "t2_timeout");

    // back-to-back single-beat reads from both masters alternate strictly
    for (int i = 0; i < 8; i++)
      push_read(i % 2, {1'(i % 2), 5'(i)}, 32'h0000_0300 + 32'(i * 8), 8'd0);
    apply();
    drain(200, "t3_timeout");

    // early w_last: sticky error, burst still completes with OKAY
    push_write(0, 6'h04, 32'h0000_4000, 8'd1, 1);
    apply();
    drain(100, "t4_timeout");
    chk("t4_wlast_err", 64'(wlast_err), 64'(1));
    repeat (5) cyc();
    chk("t4_wlast_err_sticky", 64'(wlast_err), 64'(1));

    // 256-beat write with random W stalls
    do_reset();
    chk("t5_err_cleared", 64'(wlast_err), 64'(0));
    stall = 1;
    b_seen = 0;
    push_write(0, 6'h05, 32'h0000_5000, 8'd255, 256);
    apply();
    drain(3000, "t5_timeout");
    chk("t5_wlast_err", 64'(wlast_err), 64'(0));
    chk("t5_b_count", 64'(b_seen), 64'(1));
    stall = 0;

    // asynchronous reset in the middle of a 4-beat read
    push_read(0, 6'h06, 32'h0000_6000, 8'd3);
    apply();
    k = 0;
    while (r_seen[0] < 2 && k < 50) begin
      cyc();
      k++;
    end
    chk("t6_reach_beat2", 64'(r_seen[0] >= 2), 64'(1));
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_quiet", 64'(ctrl_vec()), 64'(0));
    chk("t6_err", 64'(wlast_err), 64'(0));
    clear_models();
    @(negedge clk);
    apply();
    repeat (2) cyc();
    rstn = 1'b1;
    push_read(0, 6'h07, 32'h0000_7000, 8'd0);
    push_read(1, 6'h27, 32'h0000_7100, 8'd0);
    apply();
    drain(100, "t6_timeout");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr_axi_arb2.md
Name: ddr_axi_arb2

Overview:
- Two-master to one-slave AXI4 arbiter that shares the single LiteDRAM AXI port between the SweRV core path and a second requester (DMA/debug loader).
- Sits in the user_clk domain between the AXI CDC output and the LiteDRAM AXI slave.
- Serialises traffic: exactly one burst (read or write) is in flight at a time.
- Grants round-robin between masters and withholds all grants until DDR init completes.

Parameters:
- ID_WIDTH, 6, AXI ID width on all ports. IDs are forwarded unchanged; responses are routed by the grant register, not by ID.
- ADDR_WIDTH, 32, AXI address width.
- DATA_WIDTH, 64, AXI data width. Strobe width is DATA_WIDTH/8.

Ports:
- clk  in  1  single clock (user_clk domain).
- rstn  in  1  asynchronous active-low reset.
- i_init_done  in  1  LiteDRAM init complete; grants are issued only while this is 1.
- sN_aw_{id,addr,len[8],size[3],burst[2],valid}  in / sN_aw_ready  out  AW channel, master N (N = 0,1).
- sN_w_{data,strb,last,valid}  in / sN_w_ready  out  W channel, master N.
- sN_b_{id,resp[2],valid}  out / sN_b_ready  in  B channel, master N.
- sN_ar_{id,addr,len,size,burst,valid}  in / sN_ar_ready  out  AR channel, master N.
- sN_r_{id,data,resp,last,valid}  out / sN_r_ready  in  R channel, master N.
- m_aw_*, m_w_*, m_ar_*  out (ready in)  slave-side request channels toward LiteDRAM.
- m_b_*, m_r_*  in (ready out)  slave-side response channels from LiteDRAM.
- o_wlast_err  out  1  sticky flag: the master's w_last did not match the AW len.

Behaviour:
- State register: IDLE, AW, W, B, AR, R. Grant register g (0/1). Round-robin pointer last. 8-bit beat counter cnt; captured length len_q.
- Reset (async, rstn=0): state=IDLE, g=0, last=1 so master 0 wins first, cnt=0, o_wlast_err=0.
- Reset outputs: every valid/ready output is 0, because outputs are gated by state and IDLE drives nothing. Data/id/addr outputs are don't-care but driven from g's master.
- IDLE:
  - Stay in IDLE while i_init_done=0.
  - reqN = sN_aw_valid | sN_ar_valid.
  - Winner: the master != last if it requests, else the other requester.
  - Within the winner, write beats read (aw_valid checked first). Go to AW or AR; set g; cnt=0; len_q captured on the next state's handshake.
- Arbitration latency: a request seen at cycle N gives m_*_valid at cycle N+1. No combinational path exists from s*_valid to grant.
- AW: m_aw_* = sg_aw_*; sg_aw_ready = m_aw_ready. On handshake: len_q = aw_len, go to W. The non-granted master's ready stays 0.
- W:
  - Pass-through m_w_* = sg_w_*; sg_w_ready = m_w_ready.
  - Each handshake increments cnt.
  - On the handshake with last=1, go to B.
  - If last != (cnt==len_q) on any handshake, set o_wlast_err (sticky until reset). Forwarding continues; the burst ends on w_last.
- B: route m_b_* to sg; m_b_ready = sg_b_ready. On handshake go to IDLE and set last = g.
- AR: same as AW, using the AR channel; on handshake go to R.
- R: route m_r_* to sg. On handshake with r_last=1, go to IDLE and set last = g.
- A W beat presented before its AW is not accepted until the W state. This is legal AXI: the slave may stall.
- The non-granted master sees all readies and valids at 0, and its requests stay pending.
- Response valids outside B/R: m_b_ready and m_r_ready are 0, and nothing is routed.
- If i_init_done falls mid-burst, the current burst completes; no new grant is issued afterwards.
- Both masters requesting every cycle: grants alternate strictly 0,1,0,1.
- A master holding both aw_valid and ar_valid is served write-first on its turn.
- len=255 (256 beats): cnt is 8 bits and does not wrap before last.

Decomposition:
- Package ddr_arb_pkg holds:
  - state enum arb_state_e.
  - AXI resp constants (OKAY=2'b00, SLVERR=2'b10).
  - burst constant INCR=2'b01.
- No sub-module. The round-robin pick is a two-input function in the package.
- Channel muxing is combinational; it is selected by g and gated by state.

Test Plan:
- i_init_done=0, s0 asserts AR for 10 cycles -> m_ar_valid stays 0 and s0_ar_ready stays 0. Raise init_done -> m_ar_valid=1 exactly one cycle later.
- Concurrent s0 write (len=3) and s1 read (len=0) after reset -> s0 is granted first; 4 W beats pass; B is routed to s0 only; then s1's AR is issued and its R (id echoed) reaches s1 only.
- Both masters issue continuous single-beat reads for 8 transactions -> grant order 0,1,0,1,0,1,0,1 with no master served twice in a row.
- s0 write with aw_len=1 and w_last on beat 1 -> o_wlast_err=1 and stays 1. The burst completes and B returns OKAY to s0.
- Assert rstn=0 mid-R burst (beat 2 of 4) -> all valid/ready outputs are 0 asynchronously. After release, state is IDLE and master 0 is granted first.
- 256-beat write (len=255) with random m_w_ready stalls -> all 256 beats are forwarded in order, o_wlast_err=0, and exactly one B is returned.
